// File: rtl/lkup_rsp_merge.sv
// lkup_rsp_merge: pairs in-order TCAM responses with queued per-packet metadata.
// Optional statistics counters are enabled by defining LKUP_RSP_MERGE_STATS_EN.
`default_nettype none

package packet_switch_pkg;
    localparam int TCAM_RESULT_WIDTH = 16;
endpackage

module lkup_rsp_merge #(
    parameter int                           USERMETADATA_WIDTH = 1,
    parameter int                           TCAM_RESULT_WIDTH  = packet_switch_pkg::TCAM_RESULT_WIDTH,
    parameter int                           META_FIFO_DEPTH    = 16,
    parameter logic [TCAM_RESULT_WIDTH-1:0] DEFAULT_RESULT     = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          meta_wr,
    input  logic [USERMETADATA_WIDTH-1:0] meta_din,
    output logic                          meta_fifo_full,
    input  logic                          rsp_fifo_empty,
    output logic                          rsp_fifo_rd,
    input  logic [TCAM_RESULT_WIDTH-1:0]  tcam_rsp_result,
    input  logic                          tcam_rsp_found,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic [USERMETADATA_WIDTH-1:0] out_tuser_usermetadata,
    output logic [TCAM_RESULT_WIDTH-1:0]  out_tuser_result,
    output logic                          out_tuser_hit,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          err_orphan,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt
);

    localparam int         AW        = $clog2(META_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(META_FIFO_DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0] state, state_nxt;

    logic [USERMETADATA_WIDTH-1:0] mem [META_FIFO_DEPTH];
    logic [AW-1:0]                 wptr, rptr;
    logic [AW:0]                   count;
    logic                          meta_empty;
    logic                          meta_full;

    logic merge, orphan, meta_pop, rsp_pop, push_allowed, push;
    logic flush_exit;

    assign meta_empty     = (count == '0);
    assign meta_full      = (count == DEPTH_CNT);
    assign meta_fifo_full = meta_full;
    assign flush_exit     = meta_empty && rsp_fifo_empty && !out_tvalid && !flush_req;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (flush_req)  state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_exit) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        merge        = 1'b0;
        orphan       = 1'b0;
        meta_pop     = 1'b0;
        rsp_pop      = 1'b0;
        push_allowed = 1'b0;
        flush_done   = 1'b0;
        case (state)
            ST_RUN: begin
                push_allowed = 1'b1;
                if (!flush_req) begin
                    merge  = !rsp_fifo_empty && !meta_empty && (!out_tvalid || out_tready);
                    // A response with nothing queued and nothing arriving can never be paired.
                    orphan = !rsp_fifo_empty && meta_empty && !meta_wr;
                end
                meta_pop = merge;
                rsp_pop  = merge || orphan;
            end
            ST_FLUSH: begin
                meta_pop   = !meta_empty;
                rsp_pop    = !rsp_fifo_empty;
                flush_done = flush_exit;
            end
            default: ;
        endcase
    end

    // A pop in the same cycle frees a slot, so a write into a full FIFO is kept then.
    assign push        = meta_wr && push_allowed && (!meta_full || meta_pop);
    assign rsp_fifo_rd = rsp_pop && rst_n;

    // ---------------- metadata FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= meta_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)     wptr <= wptr + 1'b1;
            if (meta_pop) rptr <= rptr + 1'b1;
            case ({push, meta_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- merged output register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_tvalid             <= 1'b0;
            out_tuser_usermetadata <= '0;
            out_tuser_result       <= '0;
            out_tuser_hit          <= 1'b0;
        end else if (merge) begin
            out_tvalid             <= 1'b1;
            out_tuser_usermetadata <= mem[rptr];
            out_tuser_result       <= tcam_rsp_found ? tcam_rsp_result : DEFAULT_RESULT;
            out_tuser_hit          <= tcam_rsp_found;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_orphan <= 1'b0;
        end else if (orphan) begin
            err_orphan <= 1'b1;
        end
    end

    // ---------------- statistics ----------------
`ifdef LKUP_RSP_MERGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (merge) begin
            if (tcam_rsp_found && hit_cnt != 32'hFFFF_FFFF)   hit_cnt  <= hit_cnt + 1'b1;
            if (!tcam_rsp_found && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lkup_rsp_merge.sv
// Self-checking bench for lkup_rsp_merge: vector table, directed corner sequences, random vs model.
`default_nettype none

module tb_lkup_rsp_merge;

    localparam int UW = 8;
    localparam int RW = 16;
`ifdef LKUP_RSP_MERGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          meta_wr;
    logic [UW-1:0] meta_din;
    logic          meta_fifo_full;
    logic          rsp_fifo_empty;
    logic          rsp_fifo_rd;
    logic [RW-1:0] tcam_rsp_result;
    logic          tcam_rsp_found;
    logic          out_tvalid;
    logic          out_tready;
    logic [UW-1:0] out_tuser_usermetadata;
    logic [RW-1:0] out_tuser_result;
    logic          out_tuser_hit;
    logic          flush_req;
    logic          flush_done;
    logic          err_orphan;
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;

    always #5 clk = ~clk;

    lkup_rsp_merge #(
        .USERMETADATA_WIDTH(UW),
        .TCAM_RESULT_WIDTH (RW),
        .META_FIFO_DEPTH   (16)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .meta_wr               (meta_wr),
        .meta_din              (meta_din),
        .meta_fifo_full        (meta_fifo_full),
        .rsp_fifo_empty        (rsp_fifo_empty),
        .rsp_fifo_rd           (rsp_fifo_rd),
        .tcam_rsp_result       (tcam_rsp_result),
        .tcam_rsp_found        (tcam_rsp_found),
        .out_tvalid            (out_tvalid),
        .out_tready            (out_tready),
        .out_tuser_usermetadata(out_tuser_usermetadata),
        .out_tuser_result      (out_tuser_result),
        .out_tuser_hit         (out_tuser_hit),
        .flush_req             (flush_req),
        .flush_done            (flush_done),
        .err_orphan            (err_orphan),
        .hit_cnt               (hit_cnt),
        .miss_cnt              (miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          found;
    } rsp_t;

    rsp_t rq[$];
    bit   use_q = 1'b0;

    typedef struct {
        logic          wr;
        logic [UW-1:0] din;
        logic          rsp;
        logic [RW-1:0] res;
        logic          found;
        logic          rdy;
        logic          e_rd;
        logic          e_tv;
        logic [UW-1:0] e_meta;
        logic [RW-1:0] e_res;
        logic          e_hit;
        logic          e_err;
        int            e_hc;
        int            e_mc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_word();
        return 64'({out_tuser_usermetadata, out_tuser_result, out_tuser_hit});
    endfunction

    function automatic logic [63:0] cnt_word(input int h, input int m);
        return STATS ? {32'(h), 32'(m)} : 64'd0;
    endfunction

    task automatic drive_rsp();
        if (use_q) begin
            rsp_fifo_empty = (rq.size() == 0);
            if (rq.size() > 0) begin
                tcam_rsp_result = rq[0].res;
                tcam_rsp_found  = rq[0].found;
            end else begin
                tcam_rsp_result = '0;
                tcam_rsp_found  = 1'b0;
            end
        end
    endtask

    task automatic settle();
        drive_rsp();
        #1;
    endtask

    task automatic adv();
        logic rd_s;
        rd_s = rsp_fifo_rd;
        @(posedge clk);
        #1;
        if (use_q && rd_s && rq.size() > 0) void'(rq.pop_front());
    endtask

    task automatic idle_inputs();
        meta_wr         = 1'b0;
        meta_din        = '0;
        flush_req       = 1'b0;
        out_tready      = 1'b1;
        rsp_fifo_empty  = 1'b1;
        tcam_rsp_result = '0;
        tcam_rsp_found  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        rq.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_data", out_word(), 0);
        chk("rst_flags", {rsp_fifo_rd, flush_done, err_orphan, meta_fifo_full}, 0);
        chk("rst_cnt", {hit_cnt, miss_cnt}, 0);
        rst_n = 1'b1;
    endtask

    // Responses must never be popped from an empty FIFO.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_fifo_rd === 1'b1) begin
            checks++;
            if (rsp_fifo_empty !== 1'b0) begin
                errors++;
                $display("FAIL rd_when_empty actual=%b required=0", rsp_fifo_empty);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[14];

    initial begin
        // ---------------- vector table ----------------
        //          wr din    rsp res      f  rdy | rd tv meta   res      hit err hc mc
        vt[0]  = '{1, 8'h01, 0, 16'h0000, 0, 1,   0, 0, 8'h00, 16'h0000, 0, 0, 0, 0};
        vt[1]  = '{0, 8'h00, 1, 16'h005A, 1, 1,   1, 0, 8'h00, 16'h0000, 0, 0, 0, 0};
        vt[2]  = '{1, 8'h00, 0, 16'h0000, 0, 1,   0, 1, 8'h01, 16'h005A, 1, 0, 1, 0};
        vt[3]  = '{0, 8'h00, 1, 16'h005A, 0, 1,   1, 0, 8'h00, 16'h0000, 0, 0, 1, 0};
        vt[4]  = '{0, 8'h00, 0, 16'h0000, 0, 0,   0, 1, 8'h00, 16'h0000, 0, 0, 1, 1};
        vt[5]  = '{0, 8'h00, 0, 16'h0000, 0, 0,   0, 1, 8'h00, 16'h0000, 0, 0, 1, 1};
        vt[6]  = '{0, 8'h00, 0, 16'h0000, 0, 1,   0, 1, 8'h00, 16'h0000, 0, 0, 1, 1};
        vt[7]  = '{0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 8'h00, 16'h0000, 0, 0, 1, 1};
        vt[8]  = '{0, 8'h00, 1, 16'h1234, 1, 1,   1, 0, 8'h00, 16'h0000, 0, 0, 1, 1};
        vt[9]  = '{0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 8'h00, 16'h0000, 0, 1, 1, 1};
        vt[10] = '{1, 8'h5C, 1, 16'h0033, 1, 1,   0, 0, 8'h00, 16'h0000, 0, 1, 1, 1};
        vt[11] = '{0, 8'h00, 1, 16'h0033, 1, 1,   1, 0, 8'h00, 16'h0000, 0, 1, 1, 1};
        vt[12] = '{0, 8'h00, 0, 16'h0000, 0, 1,   0, 1, 8'h5C, 16'h0033, 1, 1, 2, 1};
        vt[13] = '{0, 8'h00, 0, 16'h0000, 0, 1,   0, 0, 8'h00, 16'h0000, 0, 1, 2, 1};

        do_reset();
        use_q = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) begin
            meta_wr         = vt[i].wr;
            meta_din        = vt[i].din;
            rsp_fifo_empty  = !vt[i].rsp;
            tcam_rsp_result = vt[i].res;
            tcam_rsp_found  = vt[i].found;
            out_tready      = vt[i].rdy;
            settle();
            chk($sformatf("vec%0d_rd", i), rsp_fifo_rd, vt[i].e_rd);
            chk($sformatf("vec%0d_tvalid", i), out_tvalid, vt[i].e_tv);
            if (vt[i].e_tv)
                chk($sformatf("vec%0d_data", i), out_word(),
                    64'({vt[i].e_meta, vt[i].e_res, vt[i].e_hit}));
            chk($sformatf("vec%0d_err", i), err_orphan, vt[i].e_err);
            chk($sformatf("vec%0d_cnt", i), {hit_cnt, miss_cnt}, cnt_word(vt[i].e_hc, vt[i].e_mc));
            adv();
        end

        // ---------------- reset mid-transfer discards pending output ----------------
        idle_inputs();
        meta_wr = 1'b1; meta_din = 8'hA1; settle(); adv();
        meta_wr = 1'b0; rsp_fifo_empty = 1'b0; tcam_rsp_found = 1'b1; tcam_rsp_result = 16'h00AA;
        out_tready = 1'b0; settle(); adv();
        rsp_fifo_empty = 1'b1; settle();
        chk("pend_tvalid", out_tvalid, 1);
        do_reset();
        chk("rst_mid_tvalid", out_tvalid, 0);

        // ---------------- fill to full, drop 17th, drain with stalls ----------------
        begin
            logic [63:0] eq[$];
            logic [63:0] saved;
            bit          stalled;
            int          got;
            do_reset();
            use_q = 1'b1;
            #1;
            for (int i = 0; i < 16; i++) begin
                meta_wr = 1'b1; meta_din = 8'(8'h10 + i);
                settle();
                if (i == 15) chk("fill_not_full_yet", meta_fifo_full, 0);
                adv();
            end
            meta_wr = 1'b1; meta_din = 8'hEE; settle();
            chk("full_set", meta_fifo_full, 1);
            adv();
            meta_wr = 1'b0; settle();
            chk("full_hold", meta_fifo_full, 1);
            for (int i = 0; i < 16; i++) begin
                rsp_t r;
                r.res   = 16'(16'h0100 + i * 7);
                r.found = (i % 3) != 0;
                rq.push_back(r);
                eq.push_back(64'({8'(8'h10 + i), r.found ? r.res : 16'h0000, r.found}));
            end
            got = 0;
            stalled = 1'b0;
            saved = '0;
            for (int c = 0; c < 200 && got < 16; c++) begin
                out_tready = (c % 2) == 0;
                settle();
                if (out_tvalid) begin
                    if (stalled) chk("stall_stable", out_word(), saved);
                    if (out_tready) begin
                        chk($sformatf("order%0d", got), out_word(), eq.pop_front());
                        got++;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        saved   = out_word();
                    end
                end else begin
                    stalled = 1'b0;
                end
                adv();
            end
            chk("order_count", got, 16);
            out_tready = 1'b1; settle(); adv();
            settle();
            chk("drain_not_full", meta_fifo_full, 0);
            chk("drain_err_clear", err_orphan, 0);
            // A further response finds no metadata, so the 17th write really was dropped.
            rq.push_back('{res: 16'h0001, found: 1'b1});
            settle();
            chk("drop17_orphan_rd", rsp_fifo_rd, 1);
            adv();
            settle();
            chk("drop17_err", err_orphan, 1);
            chk("drop17_no_out", out_tvalid, 0);
        end

        // ---------------- flush with pending metadata and responses ----------------
        begin
            int fd;
            int tv_seen;
            do_reset();
            use_q = 1'b1;
            #1;
            for (int i = 0; i < 3; i++) begin
                meta_wr = 1'b1; meta_din = 8'(8'h61 + i); settle(); adv();
            end
            meta_wr = 1'b0;
            rq.push_back('{res: 16'h0111, found: 1'b1});
            rq.push_back('{res: 16'h0222, found: 1'b0});
            flush_req = 1'b1;
            settle();
            chk("flush_no_merge", rsp_fifo_rd, 0);
            adv();
            flush_req = 1'b0;
            fd = 0;
            tv_seen = 0;
            for (int c = 0; c < 12; c++) begin
                meta_wr  = (fd == 0);
                meta_din = 8'h77;
                settle();
                if (out_tvalid) tv_seen++;
                if (flush_done) fd++;
                adv();
            end
            meta_wr = 1'b0;
            chk("flush_done_pulses", fd, 1);
            chk("flush_no_output", tv_seen, 0);
            chk("flush_rsp_drained", rq.size(), 0);
            chk("flush_no_orphan", err_orphan, 0);
            meta_wr = 1'b1; meta_din = 8'h42; settle(); adv();
            meta_wr = 1'b0;
            rq.push_back('{res: 16'h0099, found: 1'b1});
            settle();
            chk("run_after_flush_rd", rsp_fifo_rd, 1);
            adv();
            settle();
            chk("run_after_flush_out", {out_tvalid, out_word()}, {1'b1, 64'({8'h42, 16'h0099, 1'b1})});
            chk("flush_not_counted", {hit_cnt, miss_cnt}, cnt_word(1, 0));
            adv();

`ifdef LKUP_RSP_MERGE_STATS_EN
            force dut.miss_cnt = 32'hFFFF_FFFF;
            #1;
            release dut.miss_cnt;
            meta_wr = 1'b1; meta_din = 8'h01; settle(); adv();
            meta_wr = 1'b0;
            rq.push_back('{res: 16'h0005, found: 1'b0});
            settle(); adv();
            settle();
            chk("miss_saturate", miss_cnt, 32'hFFFF_FFFF);
            adv();
`endif
        end

        // ---------------- randomized run against reference model ----------------
        begin
            logic [UW-1:0] mq[$];
            bit            mv;
            logic [63:0]   mo;
            bit            merr;
            logic [31:0]   hc, mc;
            int            p_wr, p_rsp, p_rdy;
            do_reset();
            use_q = 1'b1;
            #1;
            mv = 0; mo = '0; merr = 0; hc = 0; mc = 0;
            p_wr = 50; p_rsp = 50; p_rdy = 50;
            for (int c = 0; c < 2000; c++) begin
                bit rsp, can, merge, orphan, accept;
                int sz;
                if (c % 250 == 0) begin
                    p_wr  = $urandom_range(20, 90);
                    p_rsp = $urandom_range(20, 90);
                    p_rdy = $urandom_range(10, 100);
                end
                meta_wr    = ($urandom % 100) < p_wr;
                meta_din   = 8'($urandom);
                out_tready = ($urandom % 100) < p_rdy;
                if (($urandom % 100) < p_rsp && rq.size() < 8) begin
                    rsp_t r;
                    r.res   = 16'($urandom);
                    r.found = $urandom % 2;
                    rq.push_back(r);
                end
                settle();
                rsp    = rq.size() > 0;
                sz     = mq.size();
                can    = !mv || out_tready;
                merge  = rsp && sz > 0 && can;
                orphan = rsp && sz == 0 && !meta_wr;
                chk("rand_rd", rsp_fifo_rd, merge || orphan);
                chk("rand_tvalid", out_tvalid, mv);
                if (mv) chk("rand_data", out_word(), mo);
                chk("rand_full", meta_fifo_full, sz == 16);
                chk("rand_err", err_orphan, merr);
                chk("rand_cnt", {hit_cnt, miss_cnt}, cnt_word(hc, mc));
                accept = meta_wr && (sz < 16 || merge);
                if (merge) begin
                    logic [UW-1:0] m;
                    m  = mq.pop_front();
                    mo = 64'({m, rq[0].found ? rq[0].res : 16'h0000, rq[0].found});
                    mv = 1;
                    if (rq[0].found) begin
                        if (hc != 32'hFFFF_FFFF) hc = hc + 1;
                    end else begin
                        if (mc != 32'hFFFF_FFFF) mc = mc + 1;
                    end
                end else if (out_tready) begin
                    mv = 0;
                end
                if (orphan) merr = 1;
                if (accept) mq.push_back(meta_din);
                adv();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
